// File: rtl/pipe_pkg.sv
// Shared pipeline package: widths, constants and IF-stage FSM encoding.
// Imported by every pipeline stage.
package pipe_pkg;

  localparam int P_ADDR_W  = 32;
  localparam int P_INSTR_W = 32;

  localparam int PC_INC = 4;

  localparam logic [P_INSTR_W-1:0] NOP_INSTR = '0;

  // IF/ID field widths: {pc, pc4} and {valid, instr}
  localparam int IFID_PC_W = 2 * P_ADDR_W;
  localparam int IFID_PL_W = P_INSTR_W + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } if_state_e;

  typedef struct packed {
    logic [P_ADDR_W-1:0]  pc;
    logic [P_ADDR_W-1:0]  pc4;
    logic [P_INSTR_W-1:0] instr;
    logic                 valid;
  } if_id_t;

endpackage

// File: rtl/if_stage_pc_ifid_reg.sv
// Generic pipeline register: async reset, sync clear, load enable.
// Clear wins over enable so a bubble can be forced while stalled.
module ifid_reg #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // next value: clear beats load beats hold
  always_comb begin
    q_d = q_q;
    if (clr_i)
      q_d = '0;
    else if (en_i)
      q_d = d_i;
  end

  // storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      q_q <= '0;
    else
      q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_stage_pc.sv
// Instruction-fetch stage: program counter, pending redirect, IF/ID register.
// Redirects seen during a stall are parked until the stall releases.
module if_stage_pc
  import pipe_pkg::*;
#(
  parameter int                ADDR_W   = P_ADDR_W,
  parameter int                INSTR_W  = P_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic [ADDR_W-1:0]  imem_addr_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [ADDR_W-1:0]  ifid_pc4_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               ifid_valid_o,
  output logic               misalign_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  if_state_e          state_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pend_q;
  logic               mis_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [ADDR_W-1:0]  tgt;
  logic [ADDR_W-1:0]  pc_inc;
  logic               hold;
  logic               bubble;
  logic               fetch_ok;
  logic               mis_d;
  logic [CNT_W-1:0]   cnt_d;

  logic [2*ADDR_W-1:0] pcs_q;
  logic [INSTR_W:0]    pl_q;

  // redirect target alignment, sequential PC and IF/ID load decisions
  always_comb begin
    tgt      = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    pc_inc   = pc_q + ADDR_W'(PC_INC);
    hold     = (state_q == ST_HOLD);
    bubble   = flush_i | redirect_i | (~stall_i & hold);
    fetch_ok = ~stall_i & ~bubble;
    mis_d    = redirect_i & (|redirect_pc_i[1:0]);
    cnt_d    = cnt_q;
    if (fetch_ok && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // PC / pending-redirect FSM with registered flag and counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
      mis_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mis_q <= mis_d;
      cnt_q <= cnt_d;
      unique case (state_q)
        ST_RUN: begin
          if (stall_i) begin
            if (redirect_i) begin
              pend_q  <= tgt;
              state_q <= ST_HOLD;
            end
          end else begin
            pc_q <= redirect_i ? tgt : pc_inc;
          end
        end
        ST_HOLD: begin
          if (stall_i) begin
            if (redirect_i)
              pend_q <= tgt;
          end else begin
            pc_q    <= redirect_i ? tgt : pend_q;
            state_q <= ST_RUN;
          end
        end
      endcase
    end
  end

  // IF/ID address fields: loaded whenever the stage advances
  ifid_reg #(
    .W (2 * ADDR_W)
  ) u_ifid_pc (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (~stall_i),
    .clr_i (1'b0),
    .d_i   ({pc_q, pc_inc}),
    .q_o   (pcs_q)
  );

  // IF/ID payload: valid + instruction, cleared for bubbles
  ifid_reg #(
    .W (INSTR_W + 1)
  ) u_ifid_pl (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (~stall_i),
    .clr_i (bubble),
    .d_i   ({1'b1, instr_i}),
    .q_o   (pl_q)
  );

  assign imem_addr_o  = pc_q;
  assign ifid_pc_o    = pcs_q[2*ADDR_W-1:ADDR_W];
  assign ifid_pc4_o   = pcs_q[ADDR_W-1:0];
  assign ifid_valid_o = pl_q[INSTR_W];
  assign ifid_instr_o = pl_q[INSTR_W-1:0];
  assign misalign_o   = mis_q;
  assign fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_if_stage_pc.sv
// Bench for if_stage_pc: directed scenarios then random stimulus,
// all compared against a behavioural fetch model.
module tb_if_stage_pc;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        redir;
  logic [31:0] rpc;
  logic [31:0] instr;
  logic [31:0] imem_addr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misalign;
  logic [3:0]  fetch_cnt;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc, m_ipc, m_ipc4, m_instr, m_pend;
  logic        m_valid, m_mis, m_pendv;
  int          m_cnt;

  if_stage_pc #(
    .ADDR_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0),
    .CNT_W    (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .instr_i       (instr),
    .imem_addr_o   (imem_addr),
    .ifid_pc_o     (ifid_pc),
    .ifid_pc4_o    (ifid_pc4),
    .ifid_instr_o  (ifid_instr),
    .ifid_valid_o  (ifid_valid),
    .misalign_o    (misalign),
    .fetch_cnt_o   (fetch_cnt)
  );

  // instruction memory: word content derived from its address
  assign instr = imem_addr | 32'h1000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_ipc4 = 0; m_instr = 0;
    m_valid = 0; m_mis = 0; m_pendv = 0; m_pend = 0; m_cnt = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".addr"},  imem_addr, m_pc);
    chk({tag, ".pc"},    ifid_pc, m_ipc);
    chk({tag, ".pc4"},   ifid_pc4, m_ipc4);
    chk({tag, ".instr"}, ifid_instr, m_instr);
    chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, m_valid});
    chk({tag, ".mis"},   {31'b0, misalign}, {31'b0, m_mis});
    chk({tag, ".cnt"},   {28'b0, fetch_cnt}, m_cnt[31:0]);
  endtask

  // what one clock edge does to the fetch stage
  task automatic model_edge(bit s, bit f, bit r, logic [31:0] a);
    logic [31:0] t;
    t = a & 32'hFFFF_FFFC;
    m_mis = r && (a % 4 != 0);
    if (!s) begin
      m_ipc  = m_pc;
      m_ipc4 = m_pc + 4;
      if (f || r || m_pendv) begin
        m_valid = 0; m_instr = 0;
      end else begin
        m_valid = 1; m_instr = m_pc | 32'h1000;
        if (m_cnt < 15) m_cnt++;
      end
      if (r)            m_pc = t;
      else if (m_pendv) m_pc = m_pend;
      else              m_pc = m_pc + 4;
      m_pendv = 0;
    end else begin
      if (f || r) begin
        m_valid = 0; m_instr = 0;
      end
      if (r) begin
        m_pendv = 1; m_pend = t;
      end
    end
  endtask

  // inputs applied at negedge, model follows the posedge, check at next negedge
  task automatic step(string tag, bit s, bit f, bit r, logic [31:0] a);
    stall = s; flush = f; redir = r; rpc = a;
    @(posedge clk);
    model_edge(s, f, r, a);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0; redir = 0; rpc = 0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // 1: sequential fetch
    for (int i = 0; i < 4; i++) step("seq", 0, 0, 0, 0);
    chk("seq.addr16", imem_addr, 32'h10);

    // 2: redirect at 0x10 to 0x40
    step("redir", 0, 0, 1, 32'h40);
    chk("redir.addr", imem_addr, 32'h40);
    chk("redir.bubble", {31'b0, ifid_valid}, 32'h0);
    step("redir1", 0, 0, 0, 0);
    chk("redir1.pc", ifid_pc, 32'h40);

    // 3: redirects during a 3-cycle stall at 0x20
    step("go20", 0, 0, 1, 32'h20);
    step("st1", 1, 0, 1, 32'h80);
    step("st2", 1, 0, 1, 32'h90);
    step("st3", 1, 0, 0, 0);
    chk("st3.hold", imem_addr, 32'h20);
    step("rel", 0, 0, 0, 0);
    chk("rel.addr", imem_addr, 32'h90);
    step("rel1", 0, 0, 0, 0);
    step("rel2", 0, 0, 0, 0);

    // live redirect in release cycle beats pending one
    step("st4", 1, 0, 1, 32'h100);
    step("rel3", 0, 0, 1, 32'h140);
    chk("rel3.addr", imem_addr, 32'h140);

    // 4: stall + flush
    step("sf", 1, 1, 0, 0);
    step("sf1", 0, 0, 0, 0);
    step("sf2", 0, 0, 0, 0);

    // 5: misaligned target
    step("mis", 0, 0, 1, 32'h43);
    chk("mis.addr", imem_addr, 32'h40);
    chk("mis.flag", {31'b0, misalign}, 32'h1);
    step("mis1", 0, 0, 0, 0);
    chk("mis1.flag", {31'b0, misalign}, 32'h0);

    // 6: saturation and PC wrap
    for (int i = 0; i < 20; i++) step("sat", 0, 0, 0, 0);
    chk("sat.cnt", {28'b0, fetch_cnt}, 32'hF);
    step("wrap0", 0, 0, 1, 32'hFFFF_FFF8);
    step("wrap1", 0, 0, 0, 0);
    step("wrap2", 0, 0, 0, 0);
    chk("wrap.addr", imem_addr, 32'h0);

    // 6: async reset while holding a pending redirect
    step("h1", 1, 0, 1, 32'h200);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("arst");
    @(negedge clk);
    rst = 1'b0;
    step("post", 0, 0, 0, 0);
    step("post1", 0, 0, 0, 0);
    chk("post.pc", ifid_pc, 32'h4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd",
           ($urandom_range(3) == 0),
           ($urandom_range(9) == 0),
           ($urandom_range(6) == 0),
           $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
